// File: rtl/cia_pkg.sv
// Shared constants and the round-robin pointer helper for the shared-adder arbiter.
package cia_pkg;

  localparam int W_DEF    = 32;
  localparam int NREQ_MAX = 8;

  function automatic int rr_next(input int id, input int nreq);
    return (id + 1 >= nreq) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/Carryincadder.sv
// Plain W-bit adder with carry-in and carry-out; the single shared instance.
module Carryincadder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/cia_rr_arbiter.sv
// Round-robin grant over NREQ requesters; pointer moves past the winner only on a transfer.
module cia_rr_arbiter
  import cia_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_vld
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = ptr_q;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    grant[grant_id] = grant_vld;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && grant_vld) ptr_d = IDW'(rr_next(int'(grant_id), NREQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cia_share_arbiter.sv
// Shares one Carryincadder among NREQ valid/ready requesters through a two-stage
// operand/response pipeline with a tagged, backpressured response bus.
module cia_share_arbiter
  import cia_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              busy
);

  logic            run_q, run_d;
  logic [W-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic            s1_cin_q, s1_cin_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s1_vld_q, s1_vld_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic            s2_load, s1_free, accept;
  logic [W-1:0]    add_sum;
  logic            add_cout, add_ovf;

  // run_q keeps every req_ready low during reset and for the first edge after release
  assign run_d     = 1'b1;
  assign s2_load   = s1_vld_q & (~rsp_valid_q | rsp_ready);
  assign s1_free   = run_q & (~s1_vld_q | s2_load);
  assign accept    = grant_vld & s1_free;
  assign req_ready = grant & {NREQ{s1_free}};

  cia_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  Carryincadder #(.W(W)) u_add (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .cin  (s1_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (s1_a_q[W-1] == s1_b_q[W-1]) && (add_sum[W-1] != s1_a_q[W-1]);

  always_comb begin
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_cin_d = s1_cin_q;
    s1_id_d  = s1_id_q;
    s1_vld_d = s1_vld_q;
    if (accept) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          s1_a_d   = req_a[i*W +: W];
          s1_b_d   = req_b[i*W +: W];
          s1_cin_d = req_cin[i];
        end
      end
      s1_id_d  = grant_id;
      s1_vld_d = 1'b1;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end
  end

  always_comb begin
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    if (s2_load) begin
      rsp_sum_d   = add_sum;
      rsp_cout_d  = add_cout;
      rsp_ovf_d   = add_ovf;
      rsp_id_d    = s1_id_q;
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_id_q     <= '0;
      s1_vld_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      run_q       <= run_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_id_q     <= s1_id_d;
      s1_vld_q    <= s1_vld_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = s1_vld_q | rsp_valid_q;

endmodule

// File: tb/tb_cia_share_arbiter.sv
// Directed bench for cia_share_arbiter: expected responses are queued at accept and
// checked in order as the response bus drains.
module tb_cia_share_arbiter;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t            sbq[$];
  int              vectors     = 0;
  int              miscompares = 0;
  logic [NREQ-1:0] hold_mask;
  logic [NREQ-1:0] acc_mask;
  logic [IDW-1:0]  last_id;
  logic [W-1:0]    last_sum;
  logic            last_cout;
  logic            last_ovf;

  cia_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [IDW-1:0] id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t        m;
    logic [W:0]  t;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    m.id   = id;
    m.sum  = t[W-1:0];
    m.cout = t[W];
    m.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
  endtask

  task automatic rand_op(input int i);
    set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // One clock: sample at the falling edge, score, then step past the rising edge.
  task automatic cyc(input bit chk_rdy = 1'b0, input logic [NREQ-1:0] exp_rdy = '0);
    exp_t e;
    #4;
    if (chk_rdy) chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    acc_mask = req_valid & req_ready;
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id",   64'(rsp_id),   64'(e.id));
        chk("rsp_sum",  64'(rsp_sum),  64'(e.sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_ovf",  64'(rsp_ovf),  64'(e.ovf));
        last_id   = rsp_id;
        last_sum  = rsp_sum;
        last_cout = rsp_cout;
        last_ovf  = rsp_ovf;
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[i])
        sbq.push_back(model(IDW'(i), req_a[i*W +: W], req_b[i*W +: W], req_cin[i]));
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[i]) begin
        if (hold_mask[i]) rand_op(i);
        else              req_valid[i] = 1'b0;
      end
  endtask

  task automatic drain();
    int n;
    rsp_ready = 1'b1;
    req_valid = '0;
    n = 0;
    while (sbq.size() > 0 && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    hold_mask = '0;
    acc_mask  = '0;
    last_id   = '0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a request pending to show ready is held off
    req_valid = 4'b0001;
    set_op(0, 32'd9, 32'd9, 1'b1);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_rsp_sum",   64'(rsp_sum),   64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic op and two-edge latency
    req_valid = 4'b0001;
    cyc(1'b1, 4'b0001);
    chk("lat1_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("lat1_busy",      64'(busy),      64'd1);
    cyc();
    chk("lat2_rsp_valid", 64'(rsp_valid), 64'd1);
    drain();
    chk("b9_id",   64'(last_id),   64'd0);
    chk("b9_sum",  64'(last_sum),  64'd19);
    chk("b9_cout", 64'(last_cout), 64'd0);
    chk("b9_ovf",  64'(last_ovf),  64'd0);

    // All requesters valid: strict rotation at full rate
    reset_dut();
    hold_mask = 4'b1111;
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) cyc(1'b1, 4'b0001 << (k % NREQ));
    hold_mask = '0;
    drain();

    // Carry-out corner
    set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    req_valid = 4'b0100;
    cyc();
    drain();
    chk("ff_id",   64'(last_id),   64'd2);
    chk("ff_sum",  64'(last_sum),  64'hFFFF_FFFF);
    chk("ff_cout", 64'(last_cout), 64'd1);
    chk("ff_ovf",  64'(last_ovf),  64'd0);

    // Signed overflow corner
    set_op(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    req_valid = 4'b0010;
    cyc();
    drain();
    chk("ov_sum",  64'(last_sum),  64'h8000_0000);
    chk("ov_cout", 64'(last_cout), 64'd0);
    chk("ov_ovf",  64'(last_ovf),  64'd1);

    // Single requester served every cycle without bubbles
    hold_mask = 4'b1000;
    rand_op(3);
    req_valid = 4'b1000;
    repeat (6) cyc(1'b1, 4'b1000);
    hold_mask = '0;
    drain();

    // Backpressure: two ops in flight, then ready drops and the response holds
    rsp_ready = 1'b0;
    hold_mask = 4'b0010;
    rand_op(1);
    req_valid = 4'b0010;
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'b0000);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_sum",   64'(rsp_sum),   64'(sbq[0].sum));
      chk("bp_rsp_id",    64'(rsp_id),    64'(sbq[0].id));
    end
    chk("bp_inflight", 64'(sbq.size()), 64'd2);
    hold_mask = '0;
    drain();

    // Reset with both stages full: outputs clear at once, pointer restarts at 0
    rsp_ready = 1'b0;
    hold_mask = 4'b0010;
    rand_op(1);
    req_valid = 4'b0010;
    cyc();
    cyc();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_rsp_sum",   64'(rsp_sum),   64'd0);
    chk("mid_rst_rsp_id",    64'(rsp_id),    64'd0);
    chk("mid_rst_flags",     64'({rsp_cout, rsp_ovf}), 64'd0);
    sbq.delete();
    hold_mask = '0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req_valid = 4'b1111;
    cyc(1'b1, 4'b0001);
    cyc(1'b1, 4'b0010);
    drain();
    repeat (3) cyc();
    chk("post_rst_idle", 64'(rsp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
